pos_filter: RTL and testbench

POS_FILTER -- requirements
Module: pos_filter

---
 rtl/pos_filter_pkg.sv | 31 +++
 rtl/pos_divider.sv | 79 +++++++
 rtl/pos_filter.sv | 202 ++++++++++++++++++++
 tb/tb_pos_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pos_filter_pkg.sv
// Shared types and frame-geometry defaults for the position filter,
// the cursor overlay and the VGA address logic.
package pos_filter_pkg;

    localparam int unsigned POS_WIDTH_DEF  = 640;
    localparam int unsigned POS_HEIGHT_DEF = 480;
    localparam int unsigned ADDR_W         = 20;
    localparam int unsigned COORD_W        = 11;
    localparam int unsigned SUM_W          = 13;
    localparam int unsigned HIST_DEPTH     = 4;
    localparam int unsigned DIV_STEPS      = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_UPDATE = 2'd3
    } pos_state_e;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        logic [COORD_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/pos_divider.sv
// Restoring shift-subtract divider by a constant: one quotient bit per cycle,
// DIV_STEPS cycles per division. done is high during the final step.
module pos_divider
    import pos_filter_pkg::*;
#(
    parameter int unsigned DIVISOR = POS_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  dividend,
    output logic               done,
    output logic [COORD_W-1:0] quotient,
    output logic [COORD_W-1:0] remainder
);

    localparam logic [COORD_W:0] DIV_L     = (COORD_W+1)'(DIVISOR);
    localparam logic [4:0]       LAST_STEP = 5'(DIV_STEPS - 1);

    logic               active_q, active_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [COORD_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0]  dq_q, dq_d;
    logic [COORD_W:0]   trial_s;
    logic [COORD_W:0]   diff_s;

    // Next-state for one division step; registers hold when idle.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        trial_s  = {rem_q, dq_q[ADDR_W-1]};
        diff_s   = trial_s - DIV_L;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = 5'd0;
            rem_d    = {COORD_W{1'b0}};
            dq_d     = dividend;
        end else if (active_q) begin
            // Quotient bits shift in behind the consumed dividend bits.
            if (trial_s >= DIV_L) begin
                rem_d = diff_s[COORD_W-1:0];
                dq_d  = {dq_q[ADDR_W-2:0], 1'b1};
            end else begin
                rem_d = trial_s[COORD_W-1:0];
                dq_d  = {dq_q[ADDR_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) begin
                active_d = 1'b0;
            end else begin
                active_d = 1'b1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Division state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            cnt_q    <= 5'd0;
            rem_q    <= {COORD_W{1'b0}};
            dq_q     <= {ADDR_W{1'b0}};
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
        end
    end

    assign done      = active_q && (cnt_q == LAST_STEP);
    assign quotient  = dq_q[COORD_W-1:0];
    assign remainder = rem_q;

endmodule

// File: rtl/pos_filter.sv
// Per-frame detection filter: splits the pixel address into row/column,
// rejects implausible jumps and outputs a 4-sample moving average.
module pos_filter
    import pos_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = POS_WIDTH_DEF,
    parameter int unsigned HEIGHT     = POS_HEIGHT_DEF,
    parameter int unsigned JUMP_MAX   = 128,
    parameter int unsigned MISS_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic [ADDR_W-1:0]  pixel_detect,
    input  logic               achou,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               pos_valid,
    output logic               busy
);

    localparam int unsigned      MISS_W     = $clog2(MISS_LIMIT + 1);
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W+1)'(WIDTH * HEIGHT);
    localparam logic [COORD_W-1:0] JUMP_L   = COORD_W'(JUMP_MAX);
    localparam logic [MISS_W-1:0]  MISS_L   = MISS_W'(MISS_LIMIT);

    pos_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               achou_q, achou_d;
    logic               hit_q, hit_d;
    logic [COORD_W-1:0] x_pos_q, x_pos_d;
    logic [COORD_W-1:0] y_pos_q, y_pos_d;
    logic               pos_valid_q, pos_valid_d;
    logic               busy_q, busy_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [1:0]         oldest_q, oldest_d;
    logic [COORD_W-1:0] hist_x_q [HIST_DEPTH];
    logic [COORD_W-1:0] hist_x_d [HIST_DEPTH];
    logic [COORD_W-1:0] hist_y_q [HIST_DEPTH];
    logic [COORD_W-1:0] hist_y_d [HIST_DEPTH];

    logic               div_start_s;
    logic               div_done_s;
    logic [COORD_W-1:0] row_s;
    logic [COORD_W-1:0] col_s;
    logic               addr_bad_s;
    logic               jump_s;
    logic [SUM_W-1:0]   sum_x_s;
    logic [SUM_W-1:0]   sum_y_s;
    logic [MISS_W-1:0]  miss_inc_s;

    assign div_start_s = (state_q == ST_IDLE) && tick;

    pos_divider #(
        .DIVISOR (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start_s),
        .dividend  (pixel_detect),
        .done      (div_done_s),
        .quotient  (row_s),
        .remainder (col_s)
    );

    // Window sums with the oldest entry already replaced by the new sample.
    always_comb begin
        sum_x_s = {SUM_W{1'b0}};
        sum_y_s = {SUM_W{1'b0}};
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (2'(i) == oldest_q) begin
                sum_x_s = sum_x_s + {2'b00, col_s};
                sum_y_s = sum_y_s + {2'b00, row_s};
            end else begin
                sum_x_s = sum_x_s + {2'b00, hist_x_q[i]};
                sum_y_s = sum_y_s + {2'b00, hist_y_q[i]};
            end
        end
    end

    // Sample classification terms.
    always_comb begin
        addr_bad_s = ({1'b0, addr_q} >= ADDR_LIMIT);
        jump_s     = pos_valid_q &&
                     ((abs_diff(row_s, y_pos_q) > JUMP_L) ||
                      (abs_diff(col_s, x_pos_q) > JUMP_L));
        if (miss_q == MISS_L) begin
            miss_inc_s = miss_q;
        end else begin
            miss_inc_s = miss_q + MISS_W'(1'b1);
        end
    end

    // FSM next state and tracking update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        achou_d     = achou_q;
        hit_d       = hit_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        pos_valid_d = pos_valid_q;
        miss_d      = miss_q;
        oldest_d    = oldest_q;
        hist_x_d    = hist_x_q;
        hist_y_d    = hist_y_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    addr_d  = pixel_detect;
                    achou_d = achou;
                    state_d = ST_DIVIDE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (div_done_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_CHECK: begin
                hit_d   = achou_q && !addr_bad_s && !jump_s;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                if (hit_q && !pos_valid_q) begin
                    // First hit after loss seeds the whole window.
                    for (int i = 0; i < HIST_DEPTH; i++) begin
                        hist_x_d[i] = col_s;
                        hist_y_d[i] = row_s;
                    end
                    oldest_d    = 2'd0;
                    x_pos_d     = col_s;
                    y_pos_d     = row_s;
                    pos_valid_d = 1'b1;
                    miss_d      = {MISS_W{1'b0}};
                end else if (hit_q) begin
                    hist_x_d[oldest_q] = col_s;
                    hist_y_d[oldest_q] = row_s;
                    oldest_d           = oldest_q + 2'd1;
                    x_pos_d            = sum_x_s[SUM_W-1:2];
                    y_pos_d            = sum_y_s[SUM_W-1:2];
                    miss_d             = {MISS_W{1'b0}};
                end else begin
                    miss_d = miss_inc_s;
                    if (miss_inc_s == MISS_L) begin
                        pos_valid_d = 1'b0;
                    end else begin
                        pos_valid_d = pos_valid_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            achou_q     <= 1'b0;
            hit_q       <= 1'b0;
            x_pos_q     <= {COORD_W{1'b0}};
            y_pos_q     <= {COORD_W{1'b0}};
            pos_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            miss_q      <= {MISS_W{1'b0}};
            oldest_q    <= 2'd0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_x_q[i] <= {COORD_W{1'b0}};
                hist_y_q[i] <= {COORD_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            achou_q     <= achou_d;
            hit_q       <= hit_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            pos_valid_q <= pos_valid_d;
            busy_q      <= busy_d;
            miss_q      <= miss_d;
            oldest_q    <= oldest_d;
            hist_x_q    <= hist_x_d;
            hist_y_q    <= hist_y_d;
        end
    end

    assign x_pos     = x_pos_q;
    assign y_pos     = y_pos_q;
    assign pos_valid = pos_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pos_filter.sv
// Randomised bench for pos_filter against a queue-based tracking model.
module tb_pos_filter;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int J  = 128;
    localparam int ML = 8;

    logic        clk;
    logic        reset_n;
    logic        tick;
    logic [19:0] pixel_detect;
    logic        achou;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        pos_valid;
    logic        busy;

    int n_vec;
    int n_err;

    // Reference model state
    int m_x, m_y, m_miss;
    bit m_valid;
    int hq_x[$];
    int hq_y[$];

    pos_filter #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .JUMP_MAX   (J),
        .MISS_LIMIT (ML)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .pixel_detect (pixel_detect),
        .achou        (achou),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .pos_valid    (pos_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_miss = 0; m_valid = 0;
        hq_x.delete(); hq_y.delete();
    endfunction

    function automatic void model_apply(input int addr, input bit ach);
        int row, col, sx, sy;
        bit hit;
        row = addr / W;
        col = addr % W;
        hit = ach && (addr < W * H);
        if (hit && m_valid && (iabs(row - m_y) > J || iabs(col - m_x) > J)) hit = 0;
        if (hit) begin
            if (!m_valid) begin
                hq_x.delete(); hq_y.delete();
                repeat (4) begin hq_x.push_back(col); hq_y.push_back(row); end
                m_x = col; m_y = row; m_valid = 1;
            end else begin
                void'(hq_x.pop_front()); void'(hq_y.pop_front());
                hq_x.push_back(col); hq_y.push_back(row);
                sx = 0; sy = 0;
                foreach (hq_x[i]) begin sx += hq_x[i]; sy += hq_y[i]; end
                m_x = sx / 4; m_y = sy / 4;
            end
            m_miss = 0;
        end else begin
            if (m_miss < ML) m_miss++;
            if (m_miss == ML) begin
                m_valid = 0;
                hq_x.delete(); hq_y.delete();
            end
        end
    endfunction

    // One accepted tick; xtra (2..23) injects a stray tick on that edge.
    task automatic run_sample(input int addr, input bit ach, input int xtra);
        int ox, oy;
        bit ov;
        ox = m_x; oy = m_y; ov = m_valid;
        pixel_detect = 20'(addr);
        achou = ach;
        tick = 1'b1;
        step();
        tick = 1'b0;
        pixel_detect = 20'($urandom);
        achou = 1'($urandom);
        for (int c = 2; c <= 22; c++) begin
            if (c == xtra) tick = 1'b1;
            step();
            tick = 1'b0;
        end
        chk("hold_x", 32'(x_pos), 32'(ox));
        chk("hold_y", 32'(y_pos), 32'(oy));
        chk("hold_valid", 32'(pos_valid), 32'(ov));
        chk("busy_mid", 32'(busy), 32'd1);
        if (xtra == 23) tick = 1'b1;
        step();
        tick = 1'b0;
        model_apply(addr, ach);
        chk("x_pos", 32'(x_pos), 32'(m_x));
        chk("y_pos", 32'(y_pos), 32'(m_y));
        chk("pos_valid", 32'(pos_valid), 32'(m_valid));
        chk("busy_end", 32'(busy), 32'd0);
        step();
        chk("idle_hold", 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, 32'(x_pos), 32'd0);
        chk({tag, "_y"}, 32'(y_pos), 32'd0);
        chk({tag, "_valid"}, 32'(pos_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int addr, row, col, r, xtra;
        bit ach;
        clk = 1'b0; reset_n = 1'b0; tick = 1'b0; pixel_detect = 20'd0; achou = 1'b0;
        n_vec = 0; n_err = 0;
        model_reset();
        repeat (3) step();
        chk_zero("reset");
        reset_n = 1'b1;
        step();

        run_sample(12345, 1'b1, 0);
        chk("seed_x", 32'(x_pos), 32'd185);
        chk("seed_y", 32'(y_pos), 32'd19);
        chk("seed_valid", 32'(pos_valid), 32'd1);
        run_sample(12349, 1'b1, 0);
        chk("avg_x", 32'(x_pos), 32'd186);
        chk("avg_y", 32'(y_pos), 32'd19);
        run_sample(300000, 1'b1, 0);
        chk("jump_x", 32'(x_pos), 32'd186);
        chk("jump_y", 32'(y_pos), 32'd19);
        chk("jump_valid", 32'(pos_valid), 32'd1);
        repeat (8) run_sample(int'($urandom_range(0, W * H - 1)), 1'b0, 0);
        chk("lost_valid", 32'(pos_valid), 32'd0);
        run_sample(640, 1'b1, 0);
        chk("reseed_x", 32'(x_pos), 32'd0);
        chk("reseed_y", 32'(y_pos), 32'd1);
        chk("reseed_valid", 32'(pos_valid), 32'd1);
        run_sample(307200, 1'b1, 5);
        chk("oob_x", 32'(x_pos), 32'd0);
        chk("oob_y", 32'(y_pos), 32'd1);
        run_sample(5 * W + 3, 1'b1, 23);

        // Reset in the middle of a division abandons the sample.
        pixel_detect = 20'd50000;
        achou = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        step();
        step();
        reset_n = 1'b1;
        model_reset();
        repeat (30) step();
        chk_zero("post_rst");
        run_sample(12345, 1'b1, 0);
        chk("first_again_x", 32'(x_pos), 32'd185);
        chk("first_again_y", 32'(y_pos), 32'd19);

        for (int n = 0; n < 70; n++) begin
            r = int'($urandom_range(0, 9));
            ach = 1'b1;
            if (r < 2) begin
                ach = 1'b0;
                addr = int'($urandom_range(0, W * H - 1));
            end else if (r == 2) begin
                addr = int'($urandom_range(W * H, 1048575));
            end else if (m_valid) begin
                row = m_y + int'($urandom_range(0, 340)) - 170;
                col = m_x + int'($urandom_range(0, 340)) - 170;
                if (row < 0) row = 0;
                if (row > H - 1) row = H - 1;
                if (col < 0) col = 0;
                if (col > W - 1) col = W - 1;
                addr = row * W + col;
            end else begin
                addr = int'($urandom_range(0, W * H - 1));
            end
            xtra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 23)) : 0;
            run_sample(addr, ach, xtra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
